// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 device-to-host receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } ps2State_e;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  localparam logic [7:0] PS2_KEY_LEFT  = 8'h6B;
  localparam logic [7:0] PS2_KEY_RIGHT = 8'h74;
  localparam logic [7:0] PS2_KEY_UP    = 8'h75;
  localparam logic [7:0] PS2_KEY_DOWN  = 8'h72;

endpackage

// File: rtl/ps2_receiver_if.sv
// Decoded scan-code bus from the PS/2 receiver to the game logic.
interface ps2_receiver_if;

  logic [7:0] code;
  logic       code_valid;
  logic       extended;
  logic       is_break;
  logic       parity_err;
  logic       frame_err;
  logic       busy;
  logic       key_left;
  logic       key_right;
  logic       key_up;
  logic       key_down;

  modport master (
    output code, code_valid, extended, is_break, parity_err, frame_err, busy,
           key_left, key_right, key_up, key_down
  );

  modport slave (
    input code, code_valid, extended, is_break, parity_err, frame_err, busy,
          key_left, key_right, key_up, key_down
  );

endinterface

// File: rtl/ps2_sync_filter.sv
// 2-FF synchronisers on the PS/2 pins plus a run-length deglitch filter on the clock,
// producing a one-cycle pulse on each filtered falling edge.
module ps2_sync_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic dataSync
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    clkSync;
  logic [1:0]    datSync;
  logic          filtClk;
  logic [CW-1:0] runCnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clkSync <= 2'b11;
      datSync <= 2'b11;
      filtClk <= 1'b1;
      runCnt  <= '0;
      fall    <= 1'b0;
    end else begin
      clkSync <= {clkSync[0], ps2_clk};
      datSync <= {datSync[0], ps2_data};
      fall    <= 1'b0;
      // runCnt counts consecutive samples that disagree with the filtered level.
      if (clkSync[1] == filtClk) begin
        runCnt <= '0;
      end else if (runCnt == CW'(FILTER_LEN - 1)) begin
        filtClk <= clkSync[1];
        runCnt  <= '0;
        fall    <= filtClk;
      end else begin
        runCnt <= runCnt + CW'(1);
      end
    end
  end

  assign dataSync = datSync[1];

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver: deframes 11-bit frames and folds E0/F0 prefixes into flags.
// Optional held arrow-key state is built when PS2_KEYSTATE_EN is defined.
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ps2_clk,
  input  logic           ps2_data,
  ps2_receiver_if.master bus
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          fall;
  logic          dataSync;
  ps2State_e     state;
  logic [2:0]    bitCnt;
  logic [7:0]    shiftReg;
  logic          parityBit;
  logic          extPending;
  logic          brkPending;
  logic [TW-1:0] tmoCnt;
  logic [7:0]    codeQ;
  logic          codeValidQ;
  logic          extQ;
  logic          brkQ;
  logic          parErrQ;
  logic          frmErrQ;
`ifdef PS2_KEYSTATE_EN
  logic [3:0]    keyQ;  // {down, up, right, left}
`endif

  ps2_sync_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_sync_filter (
    .clk     (clk),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .fall    (fall),
    .dataSync(dataSync)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= StIdle;
      bitCnt     <= '0;
      shiftReg   <= '0;
      parityBit  <= 1'b0;
      extPending <= 1'b0;
      brkPending <= 1'b0;
      tmoCnt     <= '0;
      codeQ      <= '0;
      codeValidQ <= 1'b0;
      extQ       <= 1'b0;
      brkQ       <= 1'b0;
      parErrQ    <= 1'b0;
      frmErrQ    <= 1'b0;
`ifdef PS2_KEYSTATE_EN
      keyQ       <= '0;
`endif
    end else begin
      codeValidQ <= 1'b0;
      parErrQ    <= 1'b0;
      frmErrQ    <= 1'b0;

      if (fall || state == StIdle) begin
        tmoCnt <= '0;
      end else begin
        tmoCnt <= tmoCnt + TW'(1);
      end

      if (!fall && state != StIdle && tmoCnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state      <= StIdle;
        frmErrQ    <= 1'b1;
        extPending <= 1'b0;
        brkPending <= 1'b0;
`ifdef PS2_KEYSTATE_EN
        keyQ       <= '0;
`endif
      end else if (fall) begin
        case (state)
          StIdle: begin
            // A high start bit is line noise; ignore it.
            if (!dataSync) begin
              state  <= StData;
              bitCnt <= '0;
            end
          end
          StData: begin
            shiftReg <= {dataSync, shiftReg[7:1]};
            bitCnt   <= bitCnt + 3'd1;
            if (bitCnt == 3'd7) begin
              state <= StParity;
            end
          end
          StParity: begin
            parityBit <= dataSync;
            state     <= StStop;
          end
          StStop: begin
            state <= StIdle;
            if (!dataSync) begin
              frmErrQ    <= 1'b1;
              extPending <= 1'b0;
              brkPending <= 1'b0;
            end else if (((^shiftReg) ^ parityBit) != 1'b1) begin
              parErrQ    <= 1'b1;
              extPending <= 1'b0;
              brkPending <= 1'b0;
            end else if (shiftReg == PS2_PREFIX_EXT) begin
              extPending <= 1'b1;
            end else if (shiftReg == PS2_PREFIX_BRK) begin
              brkPending <= 1'b1;
            end else begin
              codeQ      <= shiftReg;
              extQ       <= extPending;
              brkQ       <= brkPending;
              codeValidQ <= 1'b1;
              extPending <= 1'b0;
              brkPending <= 1'b0;
`ifdef PS2_KEYSTATE_EN
              if (extPending) begin
                case (shiftReg)
                  PS2_KEY_LEFT:  keyQ[0] <= ~brkPending;
                  PS2_KEY_RIGHT: keyQ[1] <= ~brkPending;
                  PS2_KEY_UP:    keyQ[2] <= ~brkPending;
                  PS2_KEY_DOWN:  keyQ[3] <= ~brkPending;
                  default: ;
                endcase
              end
`endif
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

  assign bus.code       = codeQ;
  assign bus.code_valid = codeValidQ;
  assign bus.extended   = extQ;
  assign bus.is_break   = brkQ;
  assign bus.parity_err = parErrQ;
  assign bus.frame_err  = frmErrQ;
  assign bus.busy       = (state != StIdle);

`ifdef PS2_KEYSTATE_EN
  assign bus.key_left  = keyQ[0];
  assign bus.key_right = keyQ[1];
  assign bus.key_up    = keyQ[2];
  assign bus.key_down  = keyQ[3];
`else
  assign bus.key_left  = 1'b0;
  assign bus.key_right = 1'b0;
  assign bus.key_up    = 1'b0;
  assign bus.key_down  = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_receiver.sv
// Randomised scoreboard bench for ps2_receiver with a frame-level reference model.
module tb_ps2_receiver;

  localparam int unsigned TMO  = 2000;
  localparam int          HALF = 40;  // PS/2 half period in clk cycles

  typedef struct packed {
    logic [1:0] kind;  // 0 code, 1 parity error, 2 frame error
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  logic ps2_clk;
  logic ps2_data;

  always #5 clk = ~clk;

  ps2_receiver_if bus ();

  ps2_receiver #(
    .FILTER_LEN    (8),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .bus     (bus)
  );

  ev_t        expQ[$];
  int         checks = 0;
  int         errors = 0;
  bit         mExt;
  bit         mBrk;
  logic [3:0] mKeys;  // {down, up, right, left}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] expKeys();
`ifdef PS2_KEYSTATE_EN
    return mKeys;
`else
    return 4'b0000;
`endif
  endfunction

  function automatic void modelFrame(input logic [7:0] b, input bit badPar, input bit badStop);
    ev_t e;
    e = '0;
    if (badStop || badPar) begin
      e.kind = badStop ? 2'd2 : 2'd1;
      expQ.push_back(e);
      mExt = 0;
      mBrk = 0;
    end else if (b == 8'hE0) begin
      mExt = 1;
    end else if (b == 8'hF0) begin
      mBrk = 1;
    end else begin
      e.kind = 2'd0;
      e.code = b;
      e.ext  = mExt;
      e.brk  = mBrk;
      expQ.push_back(e);
      if (mExt) begin
        if (b == 8'h6B) mKeys[0] = ~mBrk;
        if (b == 8'h74) mKeys[1] = ~mBrk;
        if (b == 8'h75) mKeys[2] = ~mBrk;
        if (b == 8'h72) mKeys[3] = ~mBrk;
      end
      mExt = 0;
      mBrk = 0;
    end
  endfunction

  // Scoreboard monitor: every strobe must match the oldest expected event.
  ev_t        gotEv;
  logic [1:0] gotKind;
  always @(negedge clk) begin
    if (reset && (bus.code_valid || bus.parity_err || bus.frame_err)) begin
      check("strobe_exclusive", 32'(bus.code_valid) + 32'(bus.parity_err) + 32'(bus.frame_err),
            32'd1);
      gotKind = bus.code_valid ? 2'd0 : (bus.parity_err ? 2'd1 : 2'd2);
      if (expQ.size() == 0) begin
        check("unexpected_strobe", {30'd0, gotKind}, 32'hFFFF_FFFF);
      end else begin
        gotEv = expQ.pop_front();
        check("strobe_kind", {30'd0, gotKind}, {30'd0, gotEv.kind});
        if (gotEv.kind == 2'd0) begin
          check("code", {24'd0, bus.code}, {24'd0, gotEv.code});
          check("extended", {31'd0, bus.extended}, {31'd0, gotEv.ext});
          check("is_break", {31'd0, bus.is_break}, {31'd0, gotEv.brk});
        end
      end
    end
  end

  task automatic sendBit(input logic v, input bit glitch);
    @(negedge clk);
    ps2_data = v;
    if (glitch) begin
      repeat (15) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (5) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (HALF - 20) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  function automatic logic [3:0] dutKeys();
    return {bus.key_down, bus.key_up, bus.key_right, bus.key_left};
  endfunction

  task automatic sendFrame(input logic [7:0] b, input bit badPar, input bit badStop,
                           input int glitchBit);
    logic [10:0] fr;
    modelFrame(b, badPar, badStop);
    fr = {~badStop, (~^b) ^ badPar, b, 1'b0};
    for (int i = 0; i < 11; i++) sendBit(fr[i], i == glitchBit);
    ps2_data = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    check("busy_after_frame", {31'd0, bus.busy}, 32'd0);
    check("keys", {28'd0, dutKeys()}, {28'd0, expKeys()});
  endtask

  initial begin
    logic [7:0] b;
    int         r;
    logic [10:0] fr;
    mExt     = 0;
    mBrk     = 0;
    mKeys    = '0;
    reset    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {21'd0, bus.code, bus.code_valid, bus.extended, bus.is_break,
          bus.parity_err, bus.frame_err, bus.busy, dutKeys() != 4'd0}, 32'd0);
    reset = 1'b1;
    repeat (20) @(negedge clk);

    // Directed sequence.
    sendFrame(8'h1C, 0, 0, -1);
    sendFrame(8'hF0, 0, 0, -1);
    sendFrame(8'h1C, 0, 0, -1);
    sendFrame(8'hE0, 0, 0, -1);
    sendFrame(8'h74, 0, 0, -1);
    check("key_right_make", {31'd0, bus.key_right}, {31'd0, expKeys() >> 1} & 32'd1);
    sendFrame(8'hE0, 0, 0, -1);
    sendFrame(8'hF0, 0, 0, -1);
    sendFrame(8'h74, 0, 0, -1);
    sendFrame(8'hE0, 0, 0, -1);
    sendFrame(8'h1C, 1, 0, -1);
    sendFrame(8'h23, 0, 0, -1);
    sendFrame(8'h1C, 0, 1, -1);

    // Timeout after start + 5 data bits.
    mExt = 1;  // an E0 precedes the aborted frame
    sendFrame(8'hE0, 0, 0, -1);
    mExt = 1;
    expQ.push_back(ev_t'{kind: 2'd2, code: 8'h00, ext: 1'b0, brk: 1'b0});
    mExt  = 0;
    mBrk  = 0;
    mKeys = '0;
    fr = {2'b10, 8'h1C, 1'b0};
    for (int i = 0; i < 6; i++) sendBit(fr[i], 0);
    repeat (HALF) @(negedge clk);
    check("busy_mid_frame", {31'd0, bus.busy}, 32'd1);
    repeat (TMO + 100) @(negedge clk);
    check("busy_after_timeout", {31'd0, bus.busy}, 32'd0);
    check("timeout_strobe_seen", expQ.size(), 32'd0);
    sendFrame(8'h2B, 0, 0, -1);

    // Deglitch: short low pulses while idle and one inside a frame.
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (20) @(negedge clk);
    end
    check("busy_after_idle_glitch", {31'd0, bus.busy}, 32'd0);
    sendFrame(8'h1C, 0, 0, 4);
    sendFrame(8'hE0, 0, 0, -1);
    sendFrame(8'h6B, 0, 0, -1);

    // Reset during data bit 4.
    fr = {2'b11, 8'h5A, 1'b0};
    for (int i = 0; i < 5; i++) sendBit(fr[i], 0);
    check("queue_empty_before_reset", expQ.size(), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midframe_reset_outputs", {21'd0, bus.code, bus.code_valid, bus.extended,
          bus.is_break, bus.parity_err, bus.frame_err, bus.busy, dutKeys() != 4'd0}, 32'd0);
    mExt  = 0;
    mBrk  = 0;
    mKeys = '0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    for (int i = 5; i < 11; i++) sendBit(1'b1, 0);
    repeat (TMO + 100) @(negedge clk);
    check("busy_after_reset_tail", {31'd0, bus.busy}, 32'd0);
    sendFrame(8'hE0, 0, 0, -1);
    sendFrame(8'h75, 0, 0, -1);

    // Randomised traffic.
    for (int n = 0; n < 25; n++) begin
      r = int'($urandom_range(0, 9));
      case ($urandom_range(0, 3))
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: begin
          case ($urandom_range(0, 3))
            0: b = 8'h6B;
            1: b = 8'h74;
            2: b = 8'h75;
            default: b = 8'h72;
          endcase
        end
        default: b = 8'($urandom_range(0, 255));
      endcase
      sendFrame(b, r == 0, r == 1, (r == 2) ? int'($urandom_range(1, 9)) : -1);
    end

    repeat (100) @(negedge clk);
    check("queue_drained", expQ.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_receiver.md
Name: ps2_receiver

Overview:
Host-side PS/2 device-to-host receiver. It synchronises and deglitches ps2_clk/ps2_data, deframes 11-bit frames, and strips E0/F0 prefixes into flags. It delivers one-cycle scan-code strobes plus optional held arrow-key state to the game logic beside the VGA controller, replacing the sw[3:0] movement inputs. The block is receive-only and never drives the PS/2 lines.

Parameters:
FILTER_LEN, 8, consecutive equal synchronised ps2_clk samples required before the filtered clock changes
TIMEOUT_CYCLES, 200000, clk cycles without a filtered falling edge before an in-progress frame is aborted (2 ms at 100 MHz)

Ports:
clk  input  1  100 MHz system clock
reset  input  1  asynchronous, active-low reset
ps2_clk  input  1  raw PS/2 clock from the pad (top level keeps it inout and tri-states it)
ps2_data  input  1  raw PS/2 data from the pad
code  output  8  last accepted scan code, prefixes removed
code_valid  output  1  one-cycle strobe; code/extended/is_break valid this cycle
extended  output  1  E0 preceded code
is_break  output  1  F0 preceded code
parity_err  output  1  one-cycle strobe on bad odd parity
frame_err  output  1  one-cycle strobe on bad stop bit or timeout
busy  output  1  high while a frame is in progress
key_left, key_right, key_up, key_down  output  1 each  held arrow state (optional feature)

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, FSM IDLE, prefix flags clear, filtered clk = 1, sync flops = 1.
- Sync: 2-FF synchroniser on each input. Filter: filtered clk takes the synced value after FILTER_LEN consecutive equal samples. Falling edge = filtered 1→0; one-cycle fall pulse.
- Data is sampled from synced ps2_data in the fall-pulse cycle.
- FSM IDLE / DATA / PARITY / STOP:
  - IDLE: on fall, if data=0 go to DATA with bit count 0. If data=1, stay in IDLE silently.
  - DATA: shift LSB-first. After the 8th bit go to PARITY.
  - PARITY: capture bit. Go to STOP.
  - STOP: on fall, return to IDLE.
    - If stop=0: pulse frame_err.
    - Else if XOR(data, parity)≠1: pulse parity_err.
    - Else accept the byte.
- Any error clears both prefix flags and produces no code_valid.
- Accepted byte:
  - E0: set ext_pending, no strobe.
  - F0: set brk_pending, no strobe.
  - Otherwise: code<=byte, extended<=ext_pending, is_break<=brk_pending, code_valid=1 for one cycle, clear both pending flags.
  - E0 F0 xx gives extended=1, is_break=1. Repeated prefixes are idempotent.
- Latency: code_valid asserts in the clk cycle after the stop-bit fall pulse. code/extended/is_break hold until the next strobe.
- Timeout: counter clears on every fall and counts while not IDLE. On reaching TIMEOUT_CYCLES: FSM to IDLE, frame_err pulse, prefix flags cleared. A counter in IDLE never fires.
- busy=1 in DATA/PARITY/STOP.
- parity_err and frame_err are never asserted together; code_valid never coincides with either.
- Mid-frame reset: immediate return to reset state; the partial byte is discarded.

Optional Feature:
PS2_KEYSTATE_EN
- Defined: on a code_valid with extended=1, codes 6B/74/75/72 drive key_left/right/up/down. Each flag is set on make and cleared on break. Non-extended codes and other codes leave the flags unchanged. Flags clear on reset and on timeout.
- Undefined: the four key outputs are tied 0 and no state registers are built.

Decomposition:
- ps2_pkg: FSM state enum; constants PS2_PREFIX_EXT=8'hE0, PS2_PREFIX_BRK=8'hF0; arrow scan constants 6B/74/75/72.
- Sub-module ps2_sync_filter: 2-FF synchronisers, FILTER_LEN filter, fall pulse and synced data out. Instantiated once.

Test Plan:
- Frame 0x1C (start 0, bits LSB-first, parity 0, stop 1) at a 12.5 kHz bus clock → one code_valid, code=1C, extended=0, is_break=0, busy low afterwards.
- F0 1C → single strobe, code=1C, is_break=1. Then E0 F0 74 → code=74, extended=1, is_break=1, and key_right 1→0 (with macro).
- Frame 0x1C with parity forced 1 → parity_err pulse, no code_valid. A following valid 0x23 has extended=0, confirming prior prefixes were cleared.
- Stop bit 0 → frame_err pulse. Separately: 5 bits, then clock idle 2.1 ms → frame_err at TIMEOUT_CYCLES, FSM IDLE, next valid frame decodes.
- 3-cycle low glitches on ps2_clk while idle, and a 5-cycle glitch mid-frame → no extra bits shifted, decoded byte correct.
- Assert reset during bit 4 of a frame → outputs 0 immediately. After release, the remaining partial bits with data=1 idle time out silently or are ignored, and a fresh 0x75 with E0 prefix sets key_up=1.
